ppi_subfilter_bank: RTL and testbench

Polyphase sub-filter bank for the PPI interpolator. It sits directly upstream of the output commutator.
- Accepts one low-rate input sample per strobe.
- Computes all gp_interpolation_factor branch outputs with one time-shared multiply-accumulate unit.
- Presents the branch outputs as one packed word that the commutator serialises to the high rate.

---
 rtl/ppi_pkg.sv | 40 ++++
 rtl/ppi_subfilter_bank_if.sv | 16 +
 rtl/ppi_mac.sv | 32 +++
 rtl/ppi_subfilter_bank.sv | 149 ++++++++++++++
 tb/tb_ppi_subfilter_bank.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/ppi_pkg.sv
// Shared types and helpers for the PPI polyphase sub-filter bank.
// PPI_BANK_SAT_EN selects saturating (defined) or wrapping (default) output reduction.
package ppi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Headroom of clog2(taps) bits keeps the full sum of one branch exact.
  function automatic int acc_width(input int idata, input int coeff, input int taps);
    return idata + coeff + clog2_min1(taps);
  endfunction

  function automatic int coeff_idx(input int p, input int t, input int l);
    return p + l * t;
  endfunction

  // Result is valid in the low ow bits, sign-extended to 64.
  function automatic logic signed [63:0] reduce_out(input logic signed [63:0] r, input int ow);
    logic signed [63:0] hi, lo;
`ifdef PPI_BANK_SAT_EN
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
`else
    hi = r <<< (64 - ow);
    lo = hi >>> (64 - ow);
    return lo;
`endif
  endfunction

endpackage

// File: rtl/ppi_subfilter_bank_if.sv
// Sample-in / packed-phases-out bus of the PPI sub-filter bank.
interface ppi_subfilter_bank_if #(
  parameter int IW = 8,
  parameter int L  = 4,
  parameter int OW = 16
);
  logic                 i_valid;
  logic signed [IW-1:0] i_data;
  logic [L*OW-1:0]      o_data;
  logic                 o_valid;
  logic                 o_busy;
  logic                 o_ovf;

  modport master (output i_valid, i_data, input o_data, o_valid, o_busy, o_ovf);
  modport slave  (input i_valid, i_data, output o_data, o_valid, o_busy, o_ovf);
endinterface

// File: rtl/ppi_mac.sv
// Time-shared signed multiply-accumulate; o_sum is the combinational next sum.
module ppi_mac #(
  parameter int IW = 8,
  parameter int CW = 8,
  parameter int AW = 18
) (
  input  logic                 i_clk,
  input  logic                 i_rst_an,
  input  logic                 i_ena,
  input  logic                 i_clr,
  input  logic                 i_acc,
  input  logic signed [IW-1:0] i_x,
  input  logic signed [CW-1:0] i_h,
  output logic signed [AW-1:0] o_sum
);
  logic signed [IW+CW-1:0] prod;
  logic signed [AW-1:0]    acc_d, acc_q;

  assign prod  = i_x * i_h;
  assign o_sum = acc_q + AW'(prod);

  always_comb begin
    acc_d = acc_q;
    if (i_clr)      acc_d = '0;
    else if (i_acc) acc_d = o_sum;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_an)  acc_q <= '0;
    else if (i_ena) acc_q <= acc_d;
  end
endmodule

// File: rtl/ppi_subfilter_bank.sv
// Polyphase sub-filter bank: one MAC computes all L branch outputs per input sample.
// PPI_BANK_SAT_EN (see ppi_pkg) selects saturating output reduction.
module ppi_subfilter_bank
  import ppi_pkg::*;
#(
  parameter int gp_idata_width          = 8,
  parameter int gp_coeff_width          = 8,
  parameter int gp_interpolation_factor = 4,
  parameter int gp_taps_per_phase       = 4,
  parameter int gp_odata_width          = 16,
  parameter int gp_shift                = 0,
  parameter logic [gp_interpolation_factor*gp_taps_per_phase*gp_coeff_width-1:0] gp_coeffs = '0
) (
  input logic i_clk,
  input logic i_rst_an,
  input logic i_ena,
  ppi_subfilter_bank_if.slave bus
);
  localparam int L   = gp_interpolation_factor;
  localparam int T   = gp_taps_per_phase;
  localparam int IW  = gp_idata_width;
  localparam int CW  = gp_coeff_width;
  localparam int OW  = gp_odata_width;
  localparam int A   = acc_width(IW, CW, T);
  localparam int PW  = clog2_min1(L);
  localparam int TW  = clog2_min1(T);
  localparam int NC  = L * T;
  localparam int CIW = clog2_min1(NC);

  logic signed [CW-1:0] coef [NC];
  for (genvar g = 0; g < NC; g++) begin : g_coef
    assign coef[g] = gp_coeffs[g*CW +: CW];
  end

  state_e                 state_q, state_d;
  logic [T-1:0][IW-1:0]   dline_q, dline_d;
  logic [PW-1:0]          phase_q, phase_d;
  logic [TW-1:0]          tap_q, tap_d;
  logic [L-1:0][OW-1:0]   stage_q, stage_d;
  logic [L-1:0][OW-1:0]   odata_q, odata_d;
  logic                   ovalid_q, ovalid_d;
  logic                   ovf_q, ovf_d;

  logic                   mac_clr, mac_acc;
  logic signed [IW-1:0]   mac_x;
  logic signed [CW-1:0]   mac_h;
  logic signed [A-1:0]    mac_sum;
  logic signed [63:0]     r64;
  logic [CIW-1:0]         cidx;
  logic                   last_tap, last_phase;

  assign last_tap   = (tap_q == TW'(T - 1));
  assign last_phase = (phase_q == PW'(L - 1));
  assign cidx       = CIW'(coeff_idx(int'(phase_q), int'(tap_q), L));
  assign mac_x      = dline_q[tap_q];
  assign mac_h      = coef[cidx];
  assign r64        = 64'(mac_sum) >>> gp_shift;

  ppi_mac #(.IW(IW), .CW(CW), .AW(A)) u_mac (
    .i_clk    (i_clk),
    .i_rst_an (i_rst_an),
    .i_ena    (i_ena),
    .i_clr    (mac_clr),
    .i_acc    (mac_acc),
    .i_x      (mac_x),
    .i_h      (mac_h),
    .o_sum    (mac_sum)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_an)  state_q <= ST_IDLE;
    else if (i_ena) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.i_valid) state_d = ST_MAC;
      ST_MAC:  if (last_tap && last_phase) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dline_d  = dline_q;
    phase_d  = phase_q;
    tap_d    = tap_q;
    stage_d  = stage_q;
    odata_d  = odata_q;
    ovalid_d = 1'b0;
    // Any strobe outside IDLE (including DONE) is dropped and flagged.
    ovf_d    = ovf_q | (bus.i_valid & (state_q != ST_IDLE));
    mac_clr  = 1'b0;
    mac_acc  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_valid) begin
          dline_d[0] = bus.i_data;
          for (int i = 1; i < T; i++) dline_d[i] = dline_q[i-1];
          mac_clr = 1'b1;
          phase_d = '0;
          tap_d   = '0;
        end
      end
      ST_MAC: begin
        if (last_tap) begin
          stage_d[phase_q] = OW'(reduce_out(r64, OW));
          mac_clr = 1'b1;
          tap_d   = '0;
          phase_d = phase_q + 1'b1;
        end else begin
          mac_acc = 1'b1;
          tap_d   = tap_q + 1'b1;
        end
      end
      ST_DONE: begin
        odata_d  = stage_q;
        ovalid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_an) begin
      dline_q  <= '0;
      phase_q  <= '0;
      tap_q    <= '0;
      stage_q  <= '0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (i_ena) begin
      dline_q  <= dline_d;
      phase_q  <= phase_d;
      tap_q    <= tap_d;
      stage_q  <= stage_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.o_data  = odata_q;
  assign bus.o_valid = ovalid_q;
  assign bus.o_busy  = (state_q != ST_IDLE);
  assign bus.o_ovf   = ovf_q;
endmodule

// File: tb/tb_ppi_subfilter_bank.sv
// Directed bench: ramp-coefficient bank (16-bit out) and all-127 bank (8-bit out).
module tb_ppi_subfilter_bank;
  logic clk, rst_an, ena;
  int   errors = 0;
  int   checks = 0;

  function automatic logic [127:0] ramp();
    logic [127:0] v;
    for (int k = 0; k < 16; k++) v[k*8 +: 8] = 8'(k + 1);
    return v;
  endfunction
  localparam logic [127:0] H_RAMP = ramp();

  ppi_subfilter_bank_if #(.IW(8), .L(4), .OW(16)) bus0 ();
  ppi_subfilter_bank_if #(.IW(8), .L(4), .OW(8))  bus1 ();

  ppi_subfilter_bank #(
    .gp_idata_width(8), .gp_coeff_width(8), .gp_interpolation_factor(4),
    .gp_taps_per_phase(4), .gp_odata_width(16), .gp_shift(0), .gp_coeffs(H_RAMP)
  ) u_dut (.i_clk(clk), .i_rst_an(rst_an), .i_ena(ena), .bus(bus0));

  ppi_subfilter_bank #(
    .gp_idata_width(8), .gp_coeff_width(8), .gp_interpolation_factor(4),
    .gp_taps_per_phase(4), .gp_odata_width(8), .gp_shift(0), .gp_coeffs({16{8'h7F}})
  ) u_sat (.i_clk(clk), .i_rst_an(rst_an), .i_ena(ena), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit    sel;
    int    x;
    int    y[4];
    string name;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit sel, input int x, input int a, input int b,
                     input int c, input int d, input string name);
    vec_t v;
    v.sel = sel; v.x = x; v.y = '{a, b, c, d}; v.name = name;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int get_y(input bit sel, input int p);
    if (sel) return int'($signed(bus1.o_data[p*8 +: 8]));
    return int'($signed(bus0.o_data[p*16 +: 16]));
  endfunction

  function automatic bit get_valid(input bit sel);
    return sel ? bus1.o_valid : bus0.o_valid;
  endfunction

  // Strobe sampled at the next rising edge; returns on the following falling edge.
  task automatic pulse(input bit sel, input int x);
    @(negedge clk);
    if (sel) begin bus1.i_valid = 1'b1; bus1.i_data = 8'(x); end
    else     begin bus0.i_valid = 1'b1; bus0.i_data = 8'(x); end
    @(negedge clk);
    bus0.i_valid = 1'b0;
    bus1.i_valid = 1'b0;
  endtask

  task automatic wait_valid(input bit sel, input int start, output int lat);
    int n;
    n   = start;
    lat = -1;
    while (n < start + 60) begin
      if (get_valid(sel)) begin lat = n; break; end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_y(input bit sel, input int y[4], input string name);
    for (int p = 0; p < 4; p++)
      check($sformatf("%s_y%0d", name, p), get_y(sel, p), y[p]);
  endtask

  task automatic do_vec(input vec_t v);
    int lat;
    pulse(v.sel, v.x);
    wait_valid(v.sel, 0, lat);
    check({v.name, "_latency"}, lat, 17);
    check_y(v.sel, v.y, v.name);
    @(negedge clk);
    check({v.name, "_pulse_end"}, int'(get_valid(v.sel)), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_an = 1'b0;
    repeat (2) @(negedge clk);
    rst_an = 1'b1;
  endtask

  initial begin
    int  lat, n;
    bit  seen;
    vec_t v;

    rst_an = 1'b0; ena = 1'b1;
    bus0.i_valid = 1'b0; bus0.i_data = '0;
    bus1.i_valid = 1'b0; bus1.i_data = '0;
    repeat (3) @(negedge clk);
    check("rst_odata", int'(bus0.o_data != '0), 0);
    check("rst_valid", int'(bus0.o_valid), 0);
    check("rst_busy",  int'(bus0.o_busy), 0);
    check("rst_ovf",   int'(bus0.o_ovf), 0);
    check("rst_sat_state", int'({bus1.o_valid, bus1.o_busy, bus1.o_ovf}), 0);
    rst_an = 1'b1;

    add(0, 1,   1,  2,  3,  4, "imp0");
    add(0, 0,   5,  6,  7,  8, "imp1");
    add(0, 0,   9, 10, 11, 12, "imp2");
    add(0, 0,  13, 14, 15, 16, "imp3");
    add(0, 0,   0,  0,  0,  0, "imp4");
    add(0, 10,  10,  20,  30,  40, "dc0");
    add(0, 10,  60,  80, 100, 120, "dc1");
    add(0, 10, 150, 180, 210, 240, "dc2");
    add(0, 10, 280, 320, 360, 400, "dc3");
    add(0, -3, 267, 294, 321, 348, "neg");
`ifdef PPI_BANK_SAT_EN
    for (int i = 0; i < 4; i++) add(1, 127, 127, 127, 127, 127, $sformatf("red_p%0d", i));
    add(1, -128,  127,  127,  127,  127, "red_n0");
    for (int i = 1; i < 4; i++) add(1, -128, -128, -128, -128, -128, $sformatf("red_n%0d", i));
`else
    for (int i = 0; i < 4; i++) add(1, 127, i + 1, i + 1, i + 1, i + 1, $sformatf("red_p%0d", i));
    add(1, -128, -125, -125, -125, -125, "red_n0");
    add(1, -128,    2,    2,    2,    2, "red_n1");
    add(1, -128, -127, -127, -127, -127, "red_n2");
    add(1, -128,    0,    0,    0,    0, "red_n3");
`endif
    foreach (tbl[i]) do_vec(tbl[i]);

    // Overflow: strobe 3 cycles after the first is dropped.
    do_reset();
    pulse(0, 1);
    @(negedge clk);
    @(negedge clk);
    check("ovf_before", int'(bus0.o_ovf), 0);
    bus0.i_valid = 1'b1; bus0.i_data = 8'sd7;
    @(negedge clk);
    bus0.i_valid = 1'b0;
    check("ovf_set", int'(bus0.o_ovf), 1);
    wait_valid(0, 3, lat);
    check("ovf_latency", lat, 17);
    check_y(0, '{1, 2, 3, 4}, "ovf_first");
    @(negedge clk);
    v.sel = 0; v.x = 0; v.y = '{5, 6, 7, 8}; v.name = "ovf_next";
    do_vec(v);
    check("ovf_sticky", int'(bus0.o_ovf), 1);

    // Enable stall of 5 cycles mid-MAC, then a held o_valid pulse.
    pulse(0, 0);
    n = 0; seen = 0;
    repeat (5) begin @(negedge clk); n++; seen |= bus0.o_valid; end
    ena = 1'b0;
    repeat (5) begin @(negedge clk); n++; seen |= bus0.o_valid; end
    ena = 1'b1;
    check("stall_busy", int'(bus0.o_busy), 1);
    wait_valid(0, n, lat);
    check("stall_latency", lat, 22);
    check("stall_no_early", int'(seen), 0);
    check_y(0, '{9, 10, 11, 12}, "stall");
    ena = 1'b0;
    repeat (3) @(negedge clk);
    check("held_valid", int'(bus0.o_valid), 1);
    ena = 1'b1;
    @(negedge clk);
    check("held_valid_end", int'(bus0.o_valid), 0);

    // Reset at cycle 8 of a computation aborts it.
    pulse(0, 0);
    repeat (7) @(negedge clk);
    rst_an = 1'b0;
    @(negedge clk);
    rst_an = 1'b1;
    check("abort_busy", int'(bus0.o_busy), 0);
    check_y(0, '{0, 0, 0, 0}, "abort_odata");
    check("abort_ovf", int'(bus0.o_ovf), 0);
    seen = 0;
    repeat (25) begin @(negedge clk); seen |= bus0.o_valid; end
    check("abort_no_valid", int'(seen), 0);
    for (int i = 0; i < 5; i++) begin
      v = tbl[i];
      v.name = {"re_", tbl[i].name};
      do_vec(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
